sid_dac_serializer: RTL and testbench
=====================================

// Module: sid_dac_serializer
// PURPOSE
// - Parametrised successor to the SID's fixed 2-channel, 12-bit serial DAC output path.
// - Takes CHANNELS parallel samples through a valid/ready handshake into a holding register.
// - Serialises each channel as a WORD_W-bit word ({cfg, sample}) on its own data line.
// - All channels share clock, chip-select and latch-enable lines (MCP49xx-style).
// - Adds a programmable bit-clock divider, MSB/LSB-first ordering, a continuous-refresh
//   mode and sticky underrun detection.
// PARAMETERS
// - CHANNELS  2   number of DAC data lines / samples per frame
// - SAMPLE_W  12  sample width per channel
// - WORD_W    16  serial word per channel; WORD_W > SAMPLE_W; CFG_W = WORD_W-SAMPLE_W
// - DIV_W     8   width of bit-clock divider setting
// PORTS
// - clk_i           in   1                 system clock
// - rst_i           in   1                 reset, asynchronous, active-high
// - sample_i        in   CHANNELS*SAMPLE_W ch0 in [SAMPLE_W-1:0]
// - sample_valid_i  in   1                 sample_i offered
// - sample_ready_o  out  1                 holding register empty
// - cfg_i           in   CHANNELS*CFG_W    per-channel config bits, prepended to sample
// - div_i           in   DIV_W             tick every div_i+1 clk_i cycles
// - msb_first_i     in   1                 1: word MSB first; 0: LSB first
// - continuous_i    in   1                 1: back-to-back frames, repeat last sample
// - clr_underrun_i  in   1                 clears underrun_o
// - dac_clk_o       out  1                 serial bit clock
// - dac_dat_o       out  CHANNELS          serial data, one line per channel
// - dac_csb_o       out  1                 chip select, active-low
// - dac_leb_o       out  1                 latch enable, active-low
// - busy_o          out  1                 frame in progress (state != IDLE)
// - underrun_o      out  1                 sticky: continuous frame started with no new sample
// - sample_raw_o    out  CHANNELS*SAMPLE_W samples of frame most recently started
// BEHAVIOUR
// - Reset values (async, immediate):
//   - outputs: dac_clk_o=0, dac_dat_o=0, dac_csb_o=1, dac_leb_o=1, busy_o=0,
//     underrun_o=0, sample_raw_o=0, sample_ready_o=1
//   - internal: state=IDLE, holding register empty, last-sample register=0
// - Reset mid-frame aborts the frame at once; the DAC sees CSB rise with no LEB pulse.
// - Handshake: accept on sample_valid_i && sample_ready_o; sample_ready_o = !pending.
//   - Cycle the holding register moves to the shifter: pending clears, ready rises next cycle.
//   - No accept and transfer in the same cycle.
// - Tick generator runs only while busy. div_i is latched at frame start.
//   - div_i=0 gives a tick every cycle.
//   - div_i changes mid-frame take effect at the next frame.
// - FSM:
//   - IDLE -> SHIFT when pending, or when continuous_i=1 (pending or not).
//   - Frame start cycle:
//     - shifter[ch] <= {cfg_i[ch], sample[ch]}; cfg_i is sampled here.
//     - sample_raw_o updates; csb falls; first bit drives dac_dat_o.
//     - Sample source: the holding register if pending, else the last-sample register.
//   - SHIFT: 2*WORD_W ticks.
//     - Even tick phase: clk=0. Odd phase: clk=1.
//     - On each tick that ends the clk=1 phase: clk falls and the next bit is presented.
//     - Data is stable across every rising edge.
//   - CS_HI: 1 tick, csb=1, clk=0.
//   - LATCH: 2 ticks, leb=0, then leb=1.
//   - Then IDLE; from IDLE the next frame may start on the very next cycle.
// - Frame length = (2*WORD_W+3)*(div_i+1) clk_i cycles, plus 1 IDLE cycle.
// - Bit order: msb_first_i sampled at frame start.
//   - 1: bit WORD_W-1 first (cfg MSB). 0: bit 0 first.
// - Underrun: continuous frame start with !pending sets underrun_o and repeats the last sample.
//   - Setting underrun_o takes priority over a simultaneous clr_underrun_i.
// - continuous_i=0 with nothing pending: stay IDLE, outputs at their reset values.
// STRUCTURE
// - sid_pkg:
//   - state enum {IDLE, SHIFT, CS_HI, LATCH}
//   - MCP49xx config constants (A/B, BUF, GA, SHDN bit positions)
// - Sub-module sid_dac_tick_gen: DIV_W down-counter with enable/clear, emits 1-cycle tick.
// - Top: FSM, phase/bit counter ($clog2(2*WORD_W) bits), CHANNELS shifters,
//   holding and last-sample registers.
// TESTING
// - Frame timing: defaults, div_i=0, msb_first=1, ch0=12'hABC, cfg0=4'h3, ch1=12'h123,
//   cfg1=4'hB -> csb low 32 cycles, 16 clk rises, dat0 bits 16'h3ABC MSB-first,
//   dat1 bits 16'hB123, leb low 2 cycles.
// - Divider: div_i=3 -> each clk phase 4 cycles; frame 140 cycles;
//   change div_i mid-frame -> timing unchanged until next frame.
// - LSB-first: msb_first=0, word 16'h0001 -> first bit 1, rest 0.
// - Continuous/underrun: continuous=1, one sample 12'h555 -> frames repeat 12'h555 on each line;
//   underrun_o set at second frame; clr_underrun_i clears it.
// - Backpressure: valid held high with new data each cycle -> ready low while pending;
//   exactly one sample accepted per frame; no sample lost or duplicated.
// - Reset mid-SHIFT: assert rst_i at bit 7 -> same cycle csb=1, leb=1, clk=0, busy=0,
//   ready=1; no LEB pulse.

Source files
------------

// File: rtl/sid_pkg.sv
// Shared types and MCP49xx config-field constants for the SID serial DAC path.
package sid_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CS_HI = 2'd2,
    LATCH = 2'd3
  } state_t;

  // Bit positions in the full 16-bit MCP49xx command word
  localparam int MCP_AB_BIT   = 15;
  localparam int MCP_BUF_BIT  = 14;
  localparam int MCP_GA_BIT   = 13;
  localparam int MCP_SHDN_BIT = 12;

  // The same fields, relative to the 4-bit config nibble prepended to a 12-bit sample
  localparam int MCP_CFG_W    = 4;
  localparam int MCP_CFG_AB   = MCP_AB_BIT   - 12;
  localparam int MCP_CFG_BUF  = MCP_BUF_BIT  - 12;
  localparam int MCP_CFG_GA   = MCP_GA_BIT   - 12;
  localparam int MCP_CFG_SHDN = MCP_SHDN_BIT - 12;

  function automatic logic [MCP_CFG_W-1:0] mcp_cfg(input logic ab, input logic buffered,
                                                    input logic ga, input logic shdn);
    logic [MCP_CFG_W-1:0] c;
    c               = '0;
    c[MCP_CFG_AB]   = ab;
    c[MCP_CFG_BUF]  = buffered;
    c[MCP_CFG_GA]   = ga;
    c[MCP_CFG_SHDN] = shdn;
    return c;
  endfunction

endpackage

// File: rtl/sid_dac_tick_gen.sv
// Bit-clock tick generator: one-cycle tick every div+1 cycles while enabled.
// Divider is captured on clear so a frame keeps its timing; no backpressure.
module sid_dac_tick_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;

  assign tick_o = en_i && !clr_i && (cnt == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt   <= '0;
      div_q <= '0;
    end else if (clr_i) begin
      cnt   <= div_i;
      div_q <= div_i;
    end else if (en_i) begin
      if (cnt == '0) cnt <= div_q;
      else           cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/sid_dac_serializer.sv
// Multi-channel MCP49xx-style serial DAC driver: one holding register, one shifter per line.
// Frame = (2*WORD_W+3)*(div+1) cycles + 1 idle; ready drops while a sample is pending.
module sid_dac_serializer
  import sid_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int SAMPLE_W = 12,
  parameter int WORD_W   = 16,
  parameter int DIV_W    = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [CHANNELS*SAMPLE_W-1:0] sample_i,
  input  logic                         sample_valid_i,
  output logic                         sample_ready_o,
  input  logic [CHANNELS*(WORD_W-SAMPLE_W)-1:0] cfg_i,
  input  logic [DIV_W-1:0]             div_i,
  input  logic                         msb_first_i,
  input  logic                         continuous_i,
  input  logic                         clr_underrun_i,
  output logic                         dac_clk_o,
  output logic [CHANNELS-1:0]          dac_dat_o,
  output logic                         dac_csb_o,
  output logic                         dac_leb_o,
  output logic                         busy_o,
  output logic                         underrun_o,
  output logic [CHANNELS*SAMPLE_W-1:0] sample_raw_o
);

  localparam int CFG_W = WORD_W - SAMPLE_W;
  localparam int PH_W  = $clog2(2 * WORD_W);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * WORD_W - 1);

  state_t                             state;
  logic [PH_W-1:0]                    ph;
  logic                               pending;
  logic [CHANNELS*SAMPLE_W-1:0]       hold_q;
  logic [CHANNELS*SAMPLE_W-1:0]       last_q;
  logic [CHANNELS*SAMPLE_W-1:0]       src;
  logic [CHANNELS-1:0][WORD_W-1:0]    shifter;
  logic [CHANNELS-1:0][WORD_W-1:0]    word;
  logic                               msb_q;
  logic                               tick;
  logic                               start;

  assign src            = pending ? hold_q : last_q;
  assign start          = (state == IDLE) && (pending || continuous_i);
  assign sample_ready_o = !pending;
  assign busy_o         = (state != IDLE);

  always_comb begin
    word = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      word[ch] = {cfg_i[ch*CFG_W +: CFG_W], src[ch*SAMPLE_W +: SAMPLE_W]};
    end
  end

  sid_dac_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (busy_o),
    .clr_i  (start),
    .div_i  (div_i),
    .tick_o (tick)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      ph           <= '0;
      pending      <= 1'b0;
      hold_q       <= '0;
      last_q       <= '0;
      shifter      <= '0;
      msb_q        <= 1'b0;
      dac_clk_o    <= 1'b0;
      dac_dat_o    <= '0;
      dac_csb_o    <= 1'b1;
      dac_leb_o    <= 1'b1;
      underrun_o   <= 1'b0;
      sample_raw_o <= '0;
    end else begin
      // Accept requires !pending and transfer requires pending, so they never collide
      if (sample_valid_i && !pending) begin
        hold_q  <= sample_i;
        pending <= 1'b1;
      end
      if (clr_underrun_i) underrun_o <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state        <= SHIFT;
            ph           <= '0;
            dac_clk_o    <= 1'b0;
            dac_csb_o    <= 1'b0;
            msb_q        <= msb_first_i;
            sample_raw_o <= src;
            if (pending) begin
              pending <= 1'b0;
              last_q  <= hold_q;
            end else begin
              underrun_o <= 1'b1;
            end
            for (int ch = 0; ch < CHANNELS; ch++) begin
              if (msb_first_i) begin
                dac_dat_o[ch] <= word[ch][WORD_W-1];
                shifter[ch]   <= {word[ch][WORD_W-2:0], 1'b0};
              end else begin
                dac_dat_o[ch] <= word[ch][0];
                shifter[ch]   <= {1'b0, word[ch][WORD_W-1:1]};
              end
            end
          end
        end

        SHIFT: begin
          if (tick) begin
            if (!ph[0]) begin
              dac_clk_o <= 1'b1;
            end else begin
              // Falling edge presents the next bit; after the last one the shifter is empty
              dac_clk_o <= 1'b0;
              for (int ch = 0; ch < CHANNELS; ch++) begin
                if (msb_q) begin
                  dac_dat_o[ch] <= shifter[ch][WORD_W-1];
                  shifter[ch]   <= {shifter[ch][WORD_W-2:0], 1'b0};
                end else begin
                  dac_dat_o[ch] <= shifter[ch][0];
                  shifter[ch]   <= {1'b0, shifter[ch][WORD_W-1:1]};
                end
              end
            end
            if (ph == PH_LAST) begin
              state     <= CS_HI;
              dac_csb_o <= 1'b1;
              ph        <= '0;
            end else begin
              ph <= ph + 1'b1;
            end
          end
        end

        CS_HI: begin
          if (tick) begin
            state     <= LATCH;
            dac_leb_o <= 1'b0;
          end
        end

        LATCH: begin
          if (tick) begin
            if (ph == '0) begin
              ph <= PH_W'(1);
            end else begin
              ph        <= '0;
              dac_leb_o <= 1'b1;
              state     <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sid_dac_serializer.sv
// Directed bench for sid_dac_serializer: table-driven frames plus continuous, backpressure and reset sequences.
module tb_sid_dac_serializer;

  localparam int CH = 2;
  localparam int SW = 12;
  localparam int WW = 16;
  localparam int DW = 8;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic [CH*SW-1:0]   sample_i;
  logic               sample_valid_i;
  logic               sample_ready_o;
  logic [CH*(WW-SW)-1:0] cfg_i;
  logic [DW-1:0]      div_i;
  logic               msb_first_i;
  logic               continuous_i;
  logic               clr_underrun_i;
  logic               dac_clk_o;
  logic [CH-1:0]      dac_dat_o;
  logic               dac_csb_o;
  logic               dac_leb_o;
  logic               busy_o;
  logic               underrun_o;
  logic [CH*SW-1:0]   sample_raw_o;

  sid_dac_serializer #(.CHANNELS(CH), .SAMPLE_W(SW), .WORD_W(WW), .DIV_W(DW)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .sample_ready_o (sample_ready_o),
    .cfg_i          (cfg_i),
    .div_i          (div_i),
    .msb_first_i    (msb_first_i),
    .continuous_i   (continuous_i),
    .clr_underrun_i (clr_underrun_i),
    .dac_clk_o      (dac_clk_o),
    .dac_dat_o      (dac_dat_o),
    .dac_csb_o      (dac_csb_o),
    .dac_leb_o      (dac_leb_o),
    .busy_o         (busy_o),
    .underrun_o     (underrun_o),
    .sample_raw_o   (sample_raw_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  div;
    logic        msb;
    logic [11:0] s0;
    logic [3:0]  c0;
    logic [11:0] s1;
    logic [3:0]  c1;
    bit          mid_div;
    logic [15:0] w0;
    logic [15:0] w1;
    int          rises;
    int          csb_lo;
    int          leb_lo;
    int          busy_n;
  } vec_t;

  vec_t vecs[4];

  // Watches one frame from its first busy cycle to the idle cycle after it.
  task automatic capture(input bit msb, input bit mid_div,
                         output logic [15:0] w0, output logic [15:0] w1,
                         output int rises, output int csb_lo, output int leb_lo, output int busy_n);
    bit   seen;
    logic prev_clk;
    int   n;
    seen = 0; prev_clk = 1'b0; n = 0;
    w0 = '0; w1 = '0; rises = 0; csb_lo = 0; leb_lo = 0; busy_n = 0;
    while (n < 3000) begin
      @(negedge clk_i);
      n++;
      if (busy_o) begin
        seen = 1;
        busy_n++;
      end else if (seen) begin
        break;
      end
      if (!dac_csb_o) csb_lo++;
      if (!dac_leb_o) leb_lo++;
      if (dac_clk_o && !prev_clk) begin
        rises++;
        if (msb) begin
          w0 = {w0[14:0], dac_dat_o[0]};
          w1 = {w1[14:0], dac_dat_o[1]};
        end else begin
          w0 = {dac_dat_o[0], w0[15:1]};
          w1 = {dac_dat_o[1], w1[15:1]};
        end
      end
      prev_clk = dac_clk_o;
      if (mid_div && busy_n == 20) div_i = 8'd0;
    end
    if (n >= 3000) begin
      checks++;
      failures++;
      $display("FAIL capture_timeout actual=%0d cycles required=frame end", n);
    end
  endtask

  logic [15:0] w0, w1;
  int rises, csb_lo, leb_lo, busy_n;
  logic [23:0] acc_q[$];
  logic [23:0] frm_q[$];

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{div:8'd0, msb:1'b1, s0:12'hABC, c0:4'h3, s1:12'h123, c1:4'hB, mid_div:1'b0,
                w0:16'h3ABC, w1:16'hB123, rises:16, csb_lo:32, leb_lo:2, busy_n:35};
    vecs[1] = '{div:8'd3, msb:1'b1, s0:12'hABC, c0:4'h3, s1:12'h123, c1:4'hB, mid_div:1'b1,
                w0:16'h3ABC, w1:16'hB123, rises:16, csb_lo:128, leb_lo:8, busy_n:140};
    vecs[2] = '{div:8'd0, msb:1'b0, s0:12'h001, c0:4'h0, s1:12'h800, c1:4'h8, mid_div:1'b0,
                w0:16'h0001, w1:16'h8800, rises:16, csb_lo:32, leb_lo:2, busy_n:35};
    vecs[3] = '{div:8'd1, msb:1'b1, s0:12'hFFF, c0:4'hF, s1:12'h000, c1:4'h0, mid_div:1'b0,
                w0:16'hFFFF, w1:16'h0000, rises:16, csb_lo:64, leb_lo:4, busy_n:70};

    rst_i = 1'b1;
    sample_i = '0; sample_valid_i = 1'b0; cfg_i = '0; div_i = '0;
    msb_first_i = 1'b1; continuous_i = 1'b0; clr_underrun_i = 1'b0;
    #1;
    check("rst_clk", dac_clk_o, 0);
    check("rst_dat", dac_dat_o, 0);
    check("rst_csb", dac_csb_o, 1);
    check("rst_leb", dac_leb_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_underrun", underrun_o, 0);
    check("rst_raw", sample_raw_o, 0);
    check("rst_ready", sample_ready_o, 1);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("idle_no_start", busy_o, 0);

    // Table-driven single frames
    for (int vi = 0; vi < 4; vi++) begin
      div_i = vecs[vi].div;
      msb_first_i = vecs[vi].msb;
      cfg_i = {vecs[vi].c1, vecs[vi].c0};
      sample_i = {vecs[vi].s1, vecs[vi].s0};
      sample_valid_i = 1'b1;
      @(negedge clk_i);
      sample_valid_i = 1'b0;
      capture(vecs[vi].msb, vecs[vi].mid_div, w0, w1, rises, csb_lo, leb_lo, busy_n);
      check($sformatf("v%0d_word0", vi), w0, vecs[vi].w0);
      check($sformatf("v%0d_word1", vi), w1, vecs[vi].w1);
      check($sformatf("v%0d_rises", vi), rises, vecs[vi].rises);
      check($sformatf("v%0d_csb_low", vi), csb_lo, vecs[vi].csb_lo);
      check($sformatf("v%0d_leb_low", vi), leb_lo, vecs[vi].leb_lo);
      check($sformatf("v%0d_frame_len", vi), busy_n, vecs[vi].busy_n);
      check($sformatf("v%0d_raw", vi), sample_raw_o, {vecs[vi].s1, vecs[vi].s0});
      check($sformatf("v%0d_idle_dat", vi), dac_dat_o, 0);
    end

    // Continuous refresh with a single sample, underrun set/clear priority
    div_i = 8'd0; msb_first_i = 1'b1; cfg_i = '0;
    sample_i = {12'h555, 12'h555};
    sample_valid_i = 1'b1;
    @(negedge clk_i);
    sample_valid_i = 1'b0;
    continuous_i = 1'b1;
    capture(1'b1, 1'b0, w0, w1, rises, csb_lo, leb_lo, busy_n);
    check("cont_f1_word0", w0, 16'h0555);
    check("cont_f1_word1", w1, 16'h0555);
    check("cont_f1_no_underrun", underrun_o, 0);
    clr_underrun_i = 1'b1;
    @(negedge clk_i);
    check("cont_f2_underrun_wins", underrun_o, 1);
    check("cont_f2_raw", sample_raw_o, {12'h555, 12'h555});
    @(negedge clk_i);
    clr_underrun_i = 1'b0;
    check("cont_clr", underrun_o, 0);
    capture(1'b1, 1'b0, w0, w1, rises, csb_lo, leb_lo, busy_n);
    capture(1'b1, 1'b0, w0, w1, rises, csb_lo, leb_lo, busy_n);
    check("cont_f3_word0", w0, 16'h0555);
    check("cont_f3_word1", w1, 16'h0555);
    check("cont_f3_len", busy_n, 35);
    check("cont_f3_underrun", underrun_o, 1);
    continuous_i = 1'b0;
    busy_n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (busy_o) busy_n++;
    end
    check("stop_busy_cycles", busy_n, 0);
    check("stop_csb", dac_csb_o, 1);
    check("stop_clk", dac_clk_o, 0);
    check("stop_dat", dac_dat_o, 0);

    // Backpressure: valid always high with fresh data every cycle
    begin
      logic [11:0] k;
      bit prev_busy;
      bit just_acc;
      k = 12'h100; prev_busy = busy_o; just_acc = 0;
      for (int c = 0; c < 130; c++) begin
        @(negedge clk_i);
        if (busy_o && !prev_busy) frm_q.push_back(sample_raw_o);
        prev_busy = busy_o;
        if (just_acc) check("bp_ready_low_pending", sample_ready_o, 0);
        sample_i = {~k, k};
        sample_valid_i = 1'b1;
        just_acc = sample_ready_o;
        if (sample_ready_o) acc_q.push_back({~k, k});
        k = k + 12'd1;
      end
      @(negedge clk_i);
      if (busy_o && !prev_busy) frm_q.push_back(sample_raw_o);
      prev_busy = busy_o;
      sample_valid_i = 1'b0;
      for (int c = 0; c < 120; c++) begin
        @(negedge clk_i);
        if (busy_o && !prev_busy) frm_q.push_back(sample_raw_o);
        prev_busy = busy_o;
      end
      check("bp_frame_count", frm_q.size(), acc_q.size());
      for (int i = 0; i < acc_q.size(); i++) begin
        if (i < frm_q.size()) check($sformatf("bp_frame%0d_data", i), frm_q[i], acc_q[i]);
      end
    end

    // Reset in the middle of SHIFT with another sample pending
    begin
      logic prev_clk;
      int r;
      int leb_seen;
      int busy_seen;
      div_i = 8'd0; msb_first_i = 1'b1; cfg_i = 8'h21;
      sample_i = {12'h3C3, 12'hC3C};
      sample_valid_i = 1'b1;
      @(negedge clk_i);
      sample_valid_i = 1'b0;
      prev_clk = 1'b0; r = 0;
      for (int n = 0; n < 500; n++) begin
        @(negedge clk_i);
        if (n == 0) begin
          sample_i = {12'h111, 12'h222};
          sample_valid_i = 1'b1;
        end
        if (n == 1) sample_valid_i = 1'b0;
        if (dac_clk_o && !prev_clk) r++;
        prev_clk = dac_clk_o;
        if (r == 7) break;
      end
      check("mid_rises_reached", r, 7);
      check("mid_pending_ready", sample_ready_o, 0);
      check("mid_csb_low", dac_csb_o, 0);
      rst_i = 1'b1;
      #1;
      check("mid_rst_csb", dac_csb_o, 1);
      check("mid_rst_leb", dac_leb_o, 1);
      check("mid_rst_clk", dac_clk_o, 0);
      check("mid_rst_busy", busy_o, 0);
      check("mid_rst_ready", sample_ready_o, 1);
      @(negedge clk_i);
      rst_i = 1'b0;
      leb_seen = 0; busy_seen = 0;
      for (int n = 0; n < 40; n++) begin
        @(negedge clk_i);
        if (!dac_leb_o) leb_seen++;
        if (busy_o) busy_seen++;
      end
      check("mid_rst_no_leb", leb_seen, 0);
      check("mid_rst_stays_idle", busy_seen, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
